// File: rtl/fifo_arb_pkg.sv
// Shared types and the circular first-set search used by the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    OPEN     = 2'd0,
    THROTTLE = 2'd1,
    BLOCKED  = 2'd2
  } arb_mode_t;

  localparam int unsigned MaxReq = 32;

  // Nearest set bit at or after ptr, wrapping at num; returns 0 when nothing is set.
  function automatic int unsigned rr_select(input logic [MaxReq-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned num);
    int unsigned idx;
    rr_select = 0;
    for (int unsigned k = MaxReq; k > 0; k--) begin
      if (k <= num) begin
        idx = ptr + k - 1;
        if (idx >= num) idx = idx - num;
        if (req[idx]) rr_select = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i, circularly.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PtrW-1:0]    ptr_i,
  output logic [PtrW-1:0]    sel_o,
  output logic               valid_o
);

  logic [MaxReq-1:0] req_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req_i;
    sel_o   = PtrW'(rr_select(req_ext, 32'(ptr_i), NUM_REQ));
    valid_o = |req_i;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin sharing of one FIFO write port with OPEN/THROTTLE/BLOCKED flow control.
// Define FIFO_ARB_STATS_EN to add per-requester grant counters and a blocked-cycle counter.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned THROTTLE_GAP = 2,
  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned GapW = $clog2(THROTTLE_GAP + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          fifo_wr_en_o,
  output logic [WIDTH-1:0]              fifo_wr_data_o,
  input  logic                          fifo_wr_valid_i,
  input  logic                          fifo_rd_en_i,
  input  logic                          fifo_full_i,
  input  logic                          fifo_almost_full_i,
  output logic                          stall_o,
  output logic [1:0]                    mode_o
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]      grant_cnt_o,
  output logic [15:0]                   blocked_cycles_o
`endif
);

  arb_mode_t       state_q, state_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [PtrW-1:0] sel;
  logic            any_req, allowed, grant, space_ok;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .sel_o   (sel),
    .valid_o (any_req)
  );

  always_comb begin
    space_ok = ~fifo_full_i | fifo_rd_en_i;
    unique case (state_q)
      OPEN:     allowed = space_ok;
      THROTTLE: allowed = (gap_q == '0) & space_ok;
      BLOCKED:  allowed = fifo_rd_en_i;
      default:  allowed = 1'b0;
    endcase

    // Outputs are forced quiet while reset is held, not just after the edge.
    fifo_wr_en_o   = ~rst_i & any_req & allowed;
    grant          = fifo_wr_en_o & fifo_wr_valid_i;
    gnt_o          = '0;
    if (grant) gnt_o[sel] = 1'b1;
    fifo_wr_data_o = any_req ? req_data_i[sel] : '0;
    stall_o        = ~rst_i & any_req & ~grant;
    mode_o         = state_q;

    rr_ptr_d = rr_ptr_q;
    if (grant) rr_ptr_d = (sel == PtrW'(NUM_REQ - 1)) ? '0 : sel + PtrW'(1);

    gap_d = '0;
    if (state_q == THROTTLE) begin
      if (grant)              gap_d = GapW'(THROTTLE_GAP);
      else if (gap_q != '0)   gap_d = gap_q - GapW'(1);
    end

    // Next mode depends only on the flags; full dominates almost_full.
    if (fifo_full_i)             state_d = BLOCKED;
    else if (fifo_almost_full_i) state_d = THROTTLE;
    else                         state_d = OPEN;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= OPEN;
      rr_ptr_q <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gap_q    <= gap_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt_q;
  logic [15:0]              blocked_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_cnt_q <= '0;
      blocked_q   <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (gnt_o[i] && grant_cnt_q[i] != 16'hFFFF) grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
      end
      if (stall_o && state_q == BLOCKED && blocked_q != 16'hFFFF) blocked_q <= blocked_q + 16'd1;
    end
  end

  assign grant_cnt_o      = grant_cnt_q;
  assign blocked_cycles_o = blocked_q;
`endif

endmodule
